// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: round-robin arbiter in front of a shared, serial
// 3x3 signed MAC engine. A granted channel's window and the shared kernel
// are captured on grant, so the requester and the kernel memory are free
// to change their inputs while the job runs. One job takes 11 cycles:
// grant edge, 9 MAC edges, 1 result edge.
//
// Handshake: req is a level request sampled only in IDLE; ack is a
// one-cycle pulse meaning "window captured, drop req now". result_valid is
// a one-cycle pulse; result/result_id/sat hold until the next job finishes.
module conv_mac_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 9
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*TAPS*DATA_WIDTH-1:0] window_flat,
  input  logic [TAPS*DATA_WIDTH-1:0]         kernel_flat,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               busy,
  output logic [2*DATA_WIDTH-1:0]            result,
  output logic [$clog2(NUM_REQ)-1:0]         result_id,
  output logic                               result_valid,
  output logic                               sat,
  output logic [1:0]                         state_dbg
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TAP_W = $clog2(TAPS);
  localparam int RES_W = 2 * DATA_WIDTH;
  localparam int ACC_W = RES_W + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{5{1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{5{1'b1}}, {(RES_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2} state_t;
  typedef logic [ID_W:0] idx_ext_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]                ptr_q, id_q, winner, ptr_next;
  logic                           found;
  logic [NUM_REQ-1:0]             winner_oh;
  logic [TAP_W-1:0]               tap_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [DATA_WIDTH-1:0]   win_q [TAPS];
  logic signed [DATA_WIDTH-1:0]   ker_q [TAPS];
  logic signed [DATA_WIDTH-1:0]   win_arr [NUM_REQ][TAPS];
  logic signed [DATA_WIDTH-1:0]   ker_arr [TAPS];
  logic signed [RES_W-1:0]        prod;
  logic [RES_W-1:0]               clamp_res;
  logic                           clamp_sat;
  logic                           last_tap;

  // Unpack the flat buses into per-channel / per-tap arrays.
  for (genvar gk = 0; gk < TAPS; gk++) begin : g_tap
    assign ker_arr[gk] = kernel_flat[gk*DATA_WIDTH +: DATA_WIDTH];
    for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_req
      assign win_arr[gr][gk] = window_flat[(gr*TAPS+gk)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin pick: first set req bit at or above ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_ext_t cand;
      cand = {1'b0, ptr_q} + idx_ext_t'(i);
      if (cand >= idx_ext_t'(NUM_REQ)) cand = cand - idx_ext_t'(NUM_REQ);
      if (!found && req[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    idx_ext_t nxt;
    nxt = {1'b0, winner} + idx_ext_t'(1);
    if (nxt >= idx_ext_t'(NUM_REQ)) nxt = '0;
    ptr_next  = nxt[ID_W-1:0];
    winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  end

  // One signed tap product per cycle; clamp the accumulator to result width.
  always_comb begin
    prod      = win_q[tap_q] * ker_q[tap_q];
    clamp_res = acc_q[RES_W-1:0];
    clamp_sat = 1'b0;
    if (acc_q > SAT_MAX) begin
      clamp_res = SAT_MAX[RES_W-1:0];
      clamp_sat = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      clamp_res = SAT_MIN[RES_W-1:0];
      clamp_sat = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_MAC;
      S_MAC:   if (last_tap) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-derived outputs and strobes.
  always_comb begin
    busy      = (state_q != S_IDLE);
    last_tap  = (state_q == S_MAC) && (tap_q == TAP_W'(TAPS-1));
    state_dbg = state_q;
  end

  // Datapath: capture on grant, accumulate in MAC, publish in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack          <= '0;
      grant        <= '0;
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
      sat          <= 1'b0;
      ptr_q        <= '0;
      id_q         <= '0;
      acc_q        <= '0;
      tap_q        <= '0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= '0;
        ker_q[k] <= '0;
      end
    end else begin
      ack          <= '0;
      result_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (found) begin
          for (int k = 0; k < TAPS; k++) begin
            win_q[k] <= win_arr[winner][k];
            ker_q[k] <= ker_arr[k];
          end
          acc_q <= '0;
          tap_q <= '0;
          grant <= winner_oh;
          ack   <= winner_oh;
          ptr_q <= ptr_next;
          id_q  <= winner;
        end
        S_MAC: begin
          acc_q <= acc_q + {{(ACC_W-RES_W){prod[RES_W-1]}}, prod};
          tap_q <= tap_q + 1'b1;
        end
        S_DONE: begin
          result       <= clamp_res;
          sat          <= clamp_sat;
          result_valid <= 1'b1;
          result_id    <= id_q;
          grant        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
